// File: rtl/textgen_glyph_attr.sv
// Glyph-row serialiser: font-ROM addressing, attribute alignment to ROM latency, pixel shift-out
// with fg/bg colour and inverse video. Blink logic is built only when TEXTGEN_BLINK_EN is defined.
module textgen_glyph_attr #(
    parameter int GLYPH_W    = 8,
    parameter int GLYPH_H    = 8,
    parameter int CHR_BITS   = 8,
    parameter int COLOR_BITS = 4,
    parameter int ROM_LAT    = 1,
    parameter int LOAD_COL   = 3,
    parameter int BLINK_DIV  = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                px_en_i,
    input  logic                                frame_i,
    input  logic [CHR_BITS-1:0]                 chr_ord_i,
    input  logic [$clog2(GLYPH_W)-1:0]          cell_col_i,
    input  logic [$clog2(GLYPH_H)-1:0]          cell_lin_i,
    input  logic [COLOR_BITS-1:0]               fg_i,
    input  logic [COLOR_BITS-1:0]               bg_i,
    input  logic                                inv_i,
    input  logic                                blink_i,
    output logic [CHR_BITS+$clog2(GLYPH_H)-1:0] rom_addr_o,
    input  logic [GLYPH_W-1:0]                  rom_data_i,
    output logic                                px_o,
    output logic [COLOR_BITS-1:0]               color_o
);

    localparam int CW = $clog2(GLYPH_W);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int AW = 2 * COLOR_BITS + 2;

    if (LOAD_COL >= GLYPH_W || ROM_LAT < 1 || ROM_LAT > 4) begin : g_param_err
        $error("textgen_glyph_attr: LOAD_COL must be < GLYPH_W and ROM_LAT within 1..4");
    end

    logic [AW-1:0]         dly [ROM_LAT];
    logic [GLYPH_W-1:0]    shift_q;
    logic [COLOR_BITS-1:0] fg_q;
    logic [COLOR_BITS-1:0] bg_q;
    logic                  inv_q;
    logic                  blink_q;
    logic                  phase;
    logic                  load;
    logic                  pix;

    assign rom_addr_o = {chr_ord_i, cell_lin_i};
    assign load       = px_en_i && (cell_col_i == CW'(LOAD_COL));

    // Attributes travel alongside the ROM read so they arrive together with rom_data_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ROM_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {fg_i, bg_i, inv_i, blink_i};
            for (int i = 1; i < ROM_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            inv_q   <= 1'b0;
            blink_q <= 1'b0;
        end else if (load) begin
            shift_q                        <= rom_data_i;
            {fg_q, bg_q, inv_q, blink_q}   <= dly[ROM_LAT-1];
        end else if (px_en_i) begin
            shift_q <= {shift_q[GLYPH_W-2:0], 1'b0};
        end
    end

`ifdef TEXTGEN_BLINK_EN
    logic [BW-1:0] blink_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_i) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    logic unused;

    // Without blink support the stored blink attribute is masked by a constant-low phase.
    assign phase  = 1'b0;
    assign unused = frame_i;
`endif

    assign pix     = shift_q[GLYPH_W-1] ^ inv_q;
    assign px_o    = pix & ~(blink_q & phase);
    assign color_o = px_o ? fg_q : bg_q;

endmodule
